// File: rtl/piso_pkg.sv
// Shared types and elaboration helpers for the parallel-in/serial-out stream serializer.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    function automatic int unsigned beats(input int unsigned width, input int unsigned lanes);
        return width / lanes;
    endfunction

    // A requested length of zero or beyond the word size means a full word.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned nbeats);
        if (len == 0 || len > nbeats) begin
            return nbeats;
        end
        return len;
    endfunction

endpackage

// File: rtl/piso_stream_serializer.sv
// Serializes WIDTH-bit words into LANES-bit beats over valid/ready on both sides.
// state | meaning
// IDLE  | no word held, ready for a new one
// SHIFT | presenting beats of the held word; reloads on the last beat for gap-free streaming
module piso_stream_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 1,
    parameter int unsigned LEN_W = $clog2(WIDTH / LANES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_msb_first,
    input  logic [LEN_W-1:0] in_len,
    output logic [LANES-1:0] ser_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);

    localparam int unsigned BEATS = beats(WIDTH, LANES);

    if (WIDTH % LANES != 0) begin : g_bad_lanes
        $error("piso_stream_serializer: WIDTH must be a multiple of LANES");
    end

    piso_state_e      state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             msb_q, msb_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             beat_done;

    assign ser_valid = (state_q == SHIFT);
    assign busy      = (state_q == SHIFT);
    assign ser_last  = ser_valid && (cnt_q == len_q - LEN_W'(1));
    assign ser_data  = ser_valid ? (msb_q ? sh_q[WIDTH-1 -: LANES] : sh_q[LANES-1:0]) : '0;
    assign in_ready  = !rst && ((state_q == IDLE) || (ser_valid && ser_last && ser_ready));

    assign accept    = in_valid && in_ready;
    assign beat_done = ser_valid && ser_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            msb_q   <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            msb_q   <= msb_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        msb_d   = msb_q;
        len_d   = len_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            SHIFT: begin
                if (beat_done) begin
                    if (ser_last) begin
                        state_d = IDLE;
                    end else begin
                        sh_d  = msb_q ? (sh_q << LANES) : (sh_q >> LANES);
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Acceptance only happens in IDLE or alongside the final beat, so it overrides the above.
        if (accept) begin
            state_d = SHIFT;
            sh_d    = in_data;
            msb_d   = in_msb_first;
            len_d   = LEN_W'(clamp_len(32'(in_len), BEATS));
            cnt_d   = '0;
        end
    end

endmodule

// File: tb/tb_piso_stream_serializer.sv
// Self-checking bench: directed word table, hand-written corner sequences, and a
// randomized run scored against a queue-of-beats reference model.
module tb_piso_stream_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid1, in_ready1, in_msb1, ser_valid1, ser_ready1, ser_last1, busy1;
    logic [7:0] in_data1;
    logic [3:0] in_len1;
    logic [0:0] ser_data1;

    logic       in_valid2, in_ready2, in_msb2, ser_valid2, ser_ready2, ser_last2, busy2;
    logic [7:0] in_data2;
    logic [2:0] in_len2;
    logic [1:0] ser_data2;

    piso_stream_serializer #(.WIDTH(8), .LANES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .in_msb_first(in_msb1), .in_len(in_len1), .ser_data(ser_data1), .ser_valid(ser_valid1),
        .ser_ready(ser_ready1), .ser_last(ser_last1), .busy(busy1)
    );

    piso_stream_serializer #(.WIDTH(8), .LANES(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .in_msb_first(in_msb2), .in_len(in_len2), .ser_data(ser_data2), .ser_valid(ser_valid2),
        .ser_ready(ser_ready2), .ser_last(ser_last2), .busy(busy2)
    );

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model for dut1: every accepted word becomes its list of beats.
    typedef struct {
        logic d;
        logic last;
    } beat_t;
    beat_t q[$];

    task automatic push_word(input logic [7:0] d, input logic m, input logic [3:0] l);
        int n;
        n = (l == 0 || l > 8) ? 8 : int'(l);
        for (int k = 0; k < n; k++) begin
            beat_t b;
            b.d    = m ? d[7-k] : d[k];
            b.last = (k == n - 1);
            q.push_back(b);
        end
    endtask

    logic m_valid, m_ready;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_in_ready", 32'(in_ready1), 0);
            chk("rst_ser_valid", 32'(ser_valid1), 0);
            chk("rst_busy", 32'(busy1), 0);
            chk("rst_ser_last", 32'(ser_last1), 0);
            chk("rst_ser_data", 32'(ser_data1), 0);
            q.delete();
        end else begin
            m_valid = (q.size() != 0);
            m_ready = !m_valid || (q[0].last && ser_ready1);
            chk("ser_valid", 32'(ser_valid1), 32'(m_valid));
            chk("busy", 32'(busy1), 32'(m_valid));
            chk("in_ready", 32'(in_ready1), 32'(m_ready));
            if (m_valid) begin
                chk("ser_data", 32'(ser_data1), 32'(q[0].d));
                chk("ser_last", 32'(ser_last1), 32'(q[0].last));
            end
            if (m_valid && ser_ready1) void'(q.pop_front());
            if (in_valid1 && m_ready) push_word(in_data1, in_msb1, in_len1);
        end
    end

    // Offer a word on dut1; called at posedge+1, returns at posedge+1 after the accepting edge.
    task automatic offer1(input logic [7:0] d, input logic m, input logic [3:0] l, input bit drop);
        bit acc = 1'b0;
        in_valid1 = 1'b1; in_data1 = d; in_msb1 = m; in_len1 = l;
        for (int c = 0; c < 64 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready1;
            @(posedge clk);
            #1;
        end
        chk("accept1", 32'(acc), 1);
        if (drop || !acc) begin
            in_valid1 = 1'b0;
            in_data1  = 8'($urandom);
            in_msb1   = 1'($urandom);
            in_len1   = 4'($urandom);
        end
    endtask

    task automatic offer2(input logic [7:0] d, input logic m, input logic [2:0] l);
        bit acc = 1'b0;
        in_valid2 = 1'b1; in_data2 = d; in_msb2 = m; in_len2 = l;
        for (int c = 0; c < 64 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready2;
            @(posedge clk);
            #1;
        end
        chk("accept2", 32'(acc), 1);
        in_valid2 = 1'b0;
        in_data2  = 8'($urandom);
    endtask

    // Gathers transferred beats until the stream goes idle; optionally stalls ser_ready.
    task automatic collect1(input int stall_at, input int stall_n, output logic [15:0] bits,
                            output int n, output int nlast, output int lidx, output int bcyc);
        bit started = 1'b0;
        int stall_left = stall_n;
        bits = '0; n = 0; nlast = 0; lidx = -1; bcyc = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (busy1) bcyc++;
            if (ser_valid1 && ser_ready1) begin
                bits = {bits[14:0], ser_data1};
                if (ser_last1) begin
                    nlast++;
                    lidx = n;
                end
                n++;
                started = 1'b1;
            end else if (!ser_valid1 && (started || cyc > 8)) begin
                break;
            end
            @(posedge clk);
            #1;
            if (n == stall_at && stall_left > 0) begin
                ser_ready1 = 1'b0;
                stall_left--;
            end else begin
                ser_ready1 = 1'b1;
            end
        end
        ser_ready1 = 1'b1;
    endtask

    task automatic collect2(output logic [15:0] bits, output int n, output int nlast, output int lidx);
        bit started = 1'b0;
        bits = '0; n = 0; nlast = 0; lidx = -1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (ser_valid2 && ser_ready2) begin
                bits = {bits[13:0], ser_data2};
                if (ser_last2) begin
                    nlast++;
                    lidx = n;
                end
                n++;
                started = 1'b1;
            end else if (!ser_valid2 && (started || cyc > 8)) begin
                break;
            end
        end
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        msb;
        logic [3:0]  len;
        int          stall_at;
        int          stall_n;
        logic [15:0] exp_bits;
        int          exp_n;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [15:0] bits;
        int n, nlast, lidx, bcyc;

        in_valid1 = 1'b0; in_data1 = '0; in_msb1 = 1'b1; in_len1 = '0; ser_ready1 = 1'b1;
        in_valid2 = 1'b0; in_data2 = '0; in_msb2 = 1'b1; in_len2 = '0; ser_ready2 = 1'b1;

        tbl[0] = '{8'hAA, 1'b1, 4'd0,  -1, 0, 16'h00AA, 8};
        tbl[1] = '{8'hC5, 1'b0, 4'd0,  -1, 0, 16'h00A3, 8};
        tbl[2] = '{8'hE0, 1'b1, 4'd3,  -1, 0, 16'h0007, 3};
        tbl[3] = '{8'hAA, 1'b1, 4'd0,   2, 3, 16'h00AA, 8};
        tbl[4] = '{8'h81, 1'b0, 4'd9,  -1, 0, 16'h0081, 8};
        tbl[5] = '{8'h5E, 1'b0, 4'd2,  -1, 0, 16'h0001, 2};
        tbl[6] = '{8'h80, 1'b1, 4'd1,  -1, 0, 16'h0001, 1};
        tbl[7] = '{8'h3C, 1'b1, 4'd15, -1, 0, 16'h003C, 8};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            offer1(tbl[i].data, tbl[i].msb, tbl[i].len, 1'b1);
            collect1(tbl[i].stall_at, tbl[i].stall_n, bits, n, nlast, lidx, bcyc);
            chk($sformatf("v%0d_bits", i), 32'(bits), 32'(tbl[i].exp_bits));
            chk($sformatf("v%0d_beats", i), n, tbl[i].exp_n);
            chk($sformatf("v%0d_nlast", i), nlast, 1);
            chk($sformatf("v%0d_last_idx", i), lidx, tbl[i].exp_n - 1);
            chk($sformatf("v%0d_busy_cycles", i), bcyc, tbl[i].exp_n + tbl[i].stall_n);
            @(posedge clk);
            #1;
        end

        // Back-to-back full words with in_valid held across the boundary.
        fork
            begin
                offer1(8'hF0, 1'b1, 4'd0, 1'b0);
                offer1(8'h0F, 1'b1, 4'd0, 1'b1);
            end
            collect1(-1, 0, bits, n, nlast, lidx, bcyc);
        join
        chk("b2b_bits", 32'(bits), 32'h0000F00F);
        chk("b2b_beats", n, 16);
        chk("b2b_nlast", nlast, 2);
        chk("b2b_busy_cycles", bcyc, 16);
        @(posedge clk);
        #1;

        // Single-beat words at one word per cycle.
        fork
            begin
                offer1(8'h80, 1'b1, 4'd1, 1'b0);
                offer1(8'h00, 1'b1, 4'd1, 1'b0);
                offer1(8'hFF, 1'b1, 4'd1, 1'b1);
            end
            collect1(-1, 0, bits, n, nlast, lidx, bcyc);
        join
        chk("single_bits", 32'(bits), 32'h5);
        chk("single_beats", n, 3);
        chk("single_nlast", nlast, 3);
        chk("single_busy_cycles", bcyc, 3);
        @(posedge clk);
        #1;

        // Reset pulsed while the fourth beat of a full word is on the output.
        offer1(8'hAA, 1'b1, 4'd0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_valid", 32'(ser_valid1), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(ser_valid1), 0);
        chk("mid_rst_busy", 32'(busy1), 0);
        chk("mid_rst_in_ready", 32'(in_ready1), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        offer1(8'h81, 1'b1, 4'd0, 1'b1);
        collect1(-1, 0, bits, n, nlast, lidx, bcyc);
        chk("post_rst_bits", 32'(bits), 32'h81);
        chk("post_rst_beats", n, 8);
        @(posedge clk);
        #1;

        // Two-lane instance.
        offer2(8'hB4, 1'b1, 3'd0);
        collect2(bits, n, nlast, lidx);
        chk("l2_msb_bits", 32'(bits), 32'hB4);
        chk("l2_msb_beats", n, 4);
        chk("l2_msb_last_idx", lidx, 3);
        @(posedge clk);
        #1;
        offer2(8'h6C, 1'b0, 3'd3);
        collect2(bits, n, nlast, lidx);
        chk("l2_lsb_len3_bits", 32'(bits), 32'h0E);
        chk("l2_lsb_len3_beats", n, 3);
        chk("l2_lsb_len3_last_idx", lidx, 2);
        @(posedge clk);
        #1;
        offer2(8'h1B, 1'b0, 3'd5);
        collect2(bits, n, nlast, lidx);
        chk("l2_lsb_clamp_bits", 32'(bits), 32'hE4);
        chk("l2_lsb_clamp_beats", n, 4);
        chk("l2_lsb_clamp_nlast", nlast, 1);
        @(posedge clk);
        #1;

        // Randomized traffic and backpressure on dut1; the monitor scores every cycle.
        for (int c = 0; c < 600; c++) begin
            in_valid1  = ($urandom_range(9) < 6);
            in_data1   = 8'($urandom);
            in_msb1    = 1'($urandom);
            in_len1    = 4'($urandom);
            ser_ready1 = ($urandom_range(3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid1  = 1'b0;
        ser_ready1 = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("drain_model_empty", 32'(q.size()), 0);
        chk("drain_busy", 32'(busy1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/piso_stream_serializer.md
# piso_stream_serializer

Parametrised parallel-in/serial-out serializer, the successor to the team's single-bit load-and-shift block. It accepts WIDTH-bit words over a valid/ready handshake and emits them LANES bits per beat. Bit order (MSB- or LSB-first) and frame length in beats are selectable per word. The output honours downstream backpressure and supports gap-free back-to-back words. It sits between word-oriented datapaths and narrow serial links (UART/SPI-style front ends) in the RTL-to-RISCV exercises.

## Interface
- WIDTH, 8: parallel word width; must be a multiple of LANES.
- LANES, 1: serial bits per beat; BEATS = WIDTH/LANES.
- LEN_W, $clog2(BEATS+1): width of in_len.
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  word offered.
- in_ready  output  1  word accepted when in_valid && in_ready.
- in_data  input  WIDTH  parallel word.
- in_msb_first  input  1  1 = MSB-first, 0 = LSB-first; sampled with the word.
- in_len  input  LEN_W  beats to send; 0 or >BEATS means BEATS.
- ser_data  output  LANES  current beat.
- ser_valid  output  1  beat valid.
- ser_ready  input  1  downstream accepts beat.
- ser_last  output  1  final beat of the word.
- busy  output  1  word in flight (state SHIFT).

## Operation
- States: IDLE and SHIFT. Reset enters IDLE.
- IDLE: in_ready=1 and ser_valid=0. Acceptance loads the shift register, mode and clamped length, clears beat counter `cnt`, and goes to SHIFT.
- SHIFT: ser_valid=1. A beat transfers on ser_valid && ser_ready, which increments `cnt`. With ser_ready low, ser_data, ser_last and cnt hold.
- Beat k slice:
  - MSB-first: in_data[WIDTH-1-k*LANES -: LANES].
  - LSB-first: in_data[k*LANES +: LANES].
  - Implementation may shift the register rather than index it, provided ser_data matches the slice above.
- Partial length L: MSB-first sends the top L*LANES bits; LSB-first sends the bottom L*LANES bits. Remaining bits are discarded.
- ser_last = ser_valid && (cnt == L-1).
- in_ready = IDLE || (ser_valid && ser_last && ser_ready), combinational. This lets a new word load on the same edge the last beat transfers, so SHIFT continues with no bubble.
- Last beat transfers with no new word accepted: return to IDLE.
- in_data, in_msb_first and in_len are ignored unless accepted.

## Timing
- Reset values: ser_data=0, ser_valid=0, ser_last=0, busy=0, cnt=0. in_ready is forced 0 while rst is high.
- Reset asserted mid-word aborts the word immediately; no further beats are emitted after reset deasserts.
- Latency: acceptance at edge N gives the first beat valid in cycle N+1 (registered).
- Throughput: one beat per cycle with ser_ready held high. A word of L beats occupies exactly L cycles, back-to-back.
- Single-beat words (L=1, or LANES=WIDTH): ser_last is high on the only beat. Consecutive words stream at one word per cycle.

## Structure
- Package piso_pkg:
  - State enum piso_state_e {IDLE, SHIFT}.
  - Function beats(WIDTH, LANES).
  - Helper that clamps len to 1..BEATS.
- Single module; no sub-module needed.
- Elaboration-time assertion: WIDTH % LANES == 0.

## Test plan
- WIDTH=8, LANES=1, in_data=8'hAA, MSB-first, len=0, ser_ready=1 -> beats 1,0,1,0,1,0,1,0; ser_last on 8th beat only; busy high for exactly 8 cycles.
- LSB-first, 8'hC5 -> 1,0,1,0,0,0,1,1.
- LANES=2, 8'hB4, MSB-first -> 2'b10, 2'b11, 2'b01, 2'b00; ser_last on 4th beat.
- Back-to-back 8'hF0 then 8'h0F with in_valid held -> 16 consecutive valid beats with no gap; in_ready pulses only with the 8th beat.
- ser_ready low on beats 3–5 of 8'hAA -> ser_data/ser_last frozen; sequence resumes unchanged; total beats still 8.
- len=3, 8'hE0, MSB-first -> 1,1,1 with ser_last on beat 3. rst pulsed during beat 4 of a full 8'hAA -> ser_valid=0, busy=0 immediately; a new 8'h81 afterwards streams correctly from beat 0.
